// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// i2c_slave : I2C target with oversampled SCL/SDA, START/STOP detection,
//             7-bit address match, byte receive and byte transmit.
// Rev 1.0
// ============================================================================
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h5A
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        sda,
  input  logic       scl,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       addr_match
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WRITE     = 3'd3,
    WRITE_ACK = 3'd4,
    READ      = 3'd5,
    READ_ACK  = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  state_t     state, state_next;
  logic       scl_s1, scl_s2, scl_prev;
  logic       sda_s1, sda_s2, sda_prev;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       rw;
  logic       sda_oe;
  logic       scl_rise, scl_fall, start_det, stop_det;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      scl_prev <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_s1   <= scl;
      scl_s2   <= scl_s1;
      scl_prev <= scl_s2;
      sda_s1   <= sda;
      sda_s2   <= sda_s1;
      sda_prev <= sda_s2;
    end
  end

  assign scl_rise  =  scl_s2 & ~scl_prev;
  assign scl_fall  = ~scl_s2 &  scl_prev;
  assign start_det =  scl_s2 &  sda_prev & ~sda_s2;
  assign stop_det  =  scl_s2 & ~sda_prev &  sda_s2;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Bus conditions override every state, including a repeated START mid-byte.
  always_comb begin
    state_next = state;
    tx_req     = 1'b0;
    if (start_det) begin
      state_next = ADDR;
    end else if (stop_det) begin
      state_next = IDLE;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise && bit_cnt == 3'd7 && shift[6:0] != SLAVE_ADDR)
            state_next = IDLE;
          else if (scl_fall && addr_match)
            state_next = ADDR_ACK;
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            state_next = rw ? READ : WRITE;
            tx_req     = rw;
          end
        end
        // A fall with the counter at zero can only follow the 8th rise.
        WRITE:     if (scl_fall && bit_cnt == 3'd0) state_next = WRITE_ACK;
        WRITE_ACK: if (scl_fall) state_next = WRITE;
        READ:      if (scl_fall && bit_cnt == 3'd7) state_next = READ_ACK;
        READ_ACK: begin
          if (scl_rise && sda_s2) begin
            state_next = WAIT_STOP;
          end else if (scl_fall) begin
            state_next = READ;
            tx_req     = 1'b1;
          end
        end
        default: state_next = state;
      endcase
    end
    if (reset) tx_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sda_oe     <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      addr_match <= 1'b0;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      rw         <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (start_det) begin
        bit_cnt    <= 3'd0;
        busy       <= 1'b1;
        sda_oe     <= 1'b0;
        addr_match <= 1'b0;
      end else if (stop_det) begin
        busy       <= 1'b0;
        addr_match <= 1'b0;
        sda_oe     <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_s2};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7 && shift[6:0] == SLAVE_ADDR) begin
                rw         <= sda_s2;
                addr_match <= 1'b1;
              end
            end else if (scl_fall && addr_match) begin
              sda_oe <= 1'b1;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 3'd0;
              if (rw) begin
                shift  <= tx_data;
                sda_oe <= ~tx_data[7];
              end else begin
                sda_oe <= 1'b0;
              end
            end
          end
          WRITE: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_s2};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= {shift[6:0], sda_s2};
                rx_valid <= 1'b1;
              end
            end else if (scl_fall && bit_cnt == 3'd0) begin
              sda_oe <= 1'b1;
            end
          end
          WRITE_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd0;
            end
          end
          READ: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 3'd0;
              end else begin
                shift   <= {shift[6:0], 1'b0};
                sda_oe  <= ~shift[6];
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          READ_ACK: begin
            if (scl_rise && sda_s2) begin
              addr_match <= 1'b0;
            end else if (scl_fall) begin
              shift   <= tx_data;
              sda_oe  <= ~tx_data[7];
              bit_cnt <= 3'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// ============================================================================
// tb_i2c_slave : bit-banged I2C master driving i2c_slave, with a scoreboard
//                for rx_valid/tx_req events. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_drv = 1'b1;
  logic       sda_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       addr_match;
  wire        sda;

  int total = 0;
  int bad = 0;
  int dut_low = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] tx_q[$];

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(7'h5A)) dut (
    .clk        (clk),
    .reset      (reset),
    .sda        (sda),
    .scl        (scl_drv),
    .tx_data    (tx_data),
    .tx_req     (tx_req),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .addr_match (addr_match)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: scores DUT pulses against queued expectations; tx_data follows
  // the supply queue except during the tx_req cycle, when it must hold.
  always @(negedge clk) begin
    if (!sda_low && sda === 1'b0) dut_low++;
    if (rx_valid) begin
      if (exp_rx.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rx_valid: got rx_data=%0h expected no pulse", rx_data);
      end else begin
        check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
      end
    end
    if (tx_req) begin
      total++;
      if (tx_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_tx_req: got pulse expected none");
      end else begin
        void'(tx_q.pop_front());
      end
    end else begin
      tx_data = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start();
    sda_low = 1'b0; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_low = 1'b1; wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic m_stop();
    sda_low = 1'b1; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_low = 1'b0; wait_clk(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_low = ~b;   wait_clk(Q);
    scl_drv = 1'b1; wait_clk(2*Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_low = 1'b0; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    b = sda;        wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = (b == 1'b0);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic m_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~m_ack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         low0;

    wait_clk(5);
    check("reset_sda", {31'd0, sda}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_pulses", {30'd0, rx_valid, tx_req}, 32'd0);
    check("reset_addr_match", {31'd0, addr_match}, 32'd0);
    reset = 1'b0;
    wait_clk(4);

    // Read 0x5A, single byte 0xC3, master NACK
    tx_q.push_back(8'hC3);
    m_start();
    check("read1_busy", {31'd0, busy}, 32'd1);
    send_byte(8'hB5, ack);
    check("read1_addr_ack", {31'd0, ack}, 32'd1);
    check("read1_addr_match", {31'd0, addr_match}, 32'd1);
    recv_byte(d, 1'b0);
    check("read1_byte", {24'd0, d}, 32'hC3);
    check("read1_nack_addr_match", {31'd0, addr_match}, 32'd0);
    m_stop();
    check("read1_busy_after_stop", {31'd0, busy}, 32'd0);
    check("read1_tx_req_count", tx_q.size(), 32'd0);

    // Write 0x5A, bytes 0xA7 and 0x01
    exp_rx.push_back(8'hA7);
    exp_rx.push_back(8'h01);
    m_start();
    send_byte(8'hB4, ack);
    check("write_addr_ack", {31'd0, ack}, 32'd1);
    send_byte(8'hA7, ack);
    check("write_ack1", {31'd0, ack}, 32'd1);
    send_byte(8'h01, ack);
    check("write_ack2", {31'd0, ack}, 32'd1);
    m_stop();
    check("write_busy_after_stop", {31'd0, busy}, 32'd0);
    check("write_rx_count", exp_rx.size(), 32'd0);
    check("write_rx_data_last", {24'd0, rx_data}, 32'h01);

    // Address mismatch 0x1E: target must never pull sda
    low0 = dut_low;
    m_start();
    send_byte(8'h3C, ack);
    check("mismatch_addr_ack", {31'd0, ack}, 32'd0);
    check("mismatch_addr_match", {31'd0, addr_match}, 32'd0);
    send_byte(8'hFF, ack);
    check("mismatch_data_ack", {31'd0, ack}, 32'd0);
    m_stop();
    check("mismatch_sda_driven", dut_low - low0, 32'd0);

    // Two-byte read with master ACK after the first byte
    tx_q.push_back(8'h5A);
    tx_q.push_back(8'h0F);
    m_start();
    send_byte(8'hB5, ack);
    check("read2_addr_ack", {31'd0, ack}, 32'd1);
    recv_byte(d, 1'b1);
    check("read2_byte1", {24'd0, d}, 32'h5A);
    check("read2_addr_match_mid", {31'd0, addr_match}, 32'd1);
    recv_byte(d, 1'b0);
    check("read2_byte2", {24'd0, d}, 32'h0F);
    m_stop();
    check("read2_tx_req_count", tx_q.size(), 32'd0);

    // Write, repeated START mid-byte, then read
    m_start();
    send_byte(8'hB4, ack);
    check("rs_write_addr_ack", {31'd0, ack}, 32'd1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    tx_q.push_back(8'h96);
    m_start();
    check("rs_addr_match_cleared", {31'd0, addr_match}, 32'd0);
    send_byte(8'hB5, ack);
    check("rs_read_addr_ack", {31'd0, ack}, 32'd1);
    recv_byte(d, 1'b0);
    check("rs_read_byte", {24'd0, d}, 32'h96);
    m_stop();
    check("rs_tx_req_count", tx_q.size(), 32'd0);
    check("rs_rx_data_unchanged", {24'd0, rx_data}, 32'h01);

    // Reset while the target is driving the address ACK
    m_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'hB4 >> i) & 8'h01) != 8'h00);
    sda_low = 1'b0;
    wait_clk(1);
    check("rst_ack_driven", {31'd0, sda}, 32'd0);
    reset = 1'b1;
    wait_clk(1);
    check("rst_sda_released", {31'd0, sda}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    scl_drv = 1'b1; wait_clk(2*Q);
    scl_drv = 1'b0; wait_clk(Q);
    check("rst_ignores_bus", {31'd0, sda}, 32'd1);
    m_stop();
    check("final_rx_pending", exp_rx.size(), 32'd0);

    wait_clk(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
